// File: rtl/systolic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : systolic_pkg                                           |
// | Description : Shared types and constants for the systolic array      |
// |               sequencer (state encoding, default sizes, PE widths).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package systolic_pkg;

   localparam int DEF_N      = 4;
   localparam int DEF_DATA_W = 8;
   localparam int ACC_W      = 17;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Number of FEED cycles needed to push a full skewed wavefront through an n x n grid
   function automatic int feed_len(input int n);
      return 3 * n - 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/skew_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : skew_mux                                               |
// | Description : Builds one diagonally skewed, zero-padded edge vector  |
// |               from a flat N*N operand buffer and the feed counter t. |
// |               Lane k carries element (k, t-k), or (t-k, k) when      |
// |               TRANSPOSE is set, and zero outside the skew window.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module skew_mux
   import systolic_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int T_W       = 4,
   parameter bit TRANSPOSE = 1'b0
) (
   input  logic [T_W-1:0]        i_t,
   input  logic [N*N*DATA_W-1:0] i_buf,
   output logic [N*DATA_W-1:0]   o_edge
);

   // Select the element on the current anti-diagonal for every lane; lanes outside the window stay zero
   always_comb begin
      o_edge = '0;
      for (int k = 0; k < N; k++) begin
         for (int d = 0; d < N; d++) begin
            if (int'(i_t) == k + d) begin
               if (TRANSPOSE)
                  o_edge[k*DATA_W +: DATA_W] = i_buf[(d*N + k)*DATA_W +: DATA_W];
               else
                  o_edge[k*DATA_W +: DATA_W] = i_buf[(k*N + d)*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/systolic_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : systolic_ctrl                                          |
// | Description : Sequencer for an N x N MAC processing-element grid.    |
// |               Buffers operand matrices A and B, clears the grid on   |
// |               start, then feeds skewed rows of A (west edge) and     |
// |               columns of B (north edge), and pulses done once every  |
// |               accumulator holds its final C element.                 |
// |               Optional: define SYSTOLIC_CTRL_JOB_CNT_EN to add a     |
// |               32-bit completed-job counter output (job_count).       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = $clog2(N*N)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic                wr_sel,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                array_rst,
   output logic [N*DATA_W-1:0] a_edge,
   output logic [N*DATA_W-1:0] b_edge
`ifdef SYSTOLIC_CTRL_JOB_CNT_EN
   ,
   output logic [31:0]         job_count
`endif
);

   localparam int             c_feed_len = feed_len(N);
   localparam int             c_t_w      = $clog2(c_feed_len);
   localparam logic [c_t_w-1:0] c_t_last = c_t_w'(c_feed_len - 1);

   state_t                  r_state;
   state_t                  w_state_next;
   logic [c_t_w-1:0]        r_t;
   logic [c_t_w-1:0]        w_t_next;
   logic [N*N*DATA_W-1:0]   r_a_buf;
   logic [N*N*DATA_W-1:0]   r_b_buf;
   logic [N*DATA_W-1:0]     w_a_skew;
   logic [N*DATA_W-1:0]     w_b_skew;
   logic                    w_wr_ok;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_array_rst;
   logic [N*DATA_W-1:0]     r_a_edge;
   logic [N*DATA_W-1:0]     r_b_edge;

   // Writes land only while idle so the operands cannot change under a running job
   assign w_wr_ok = wr_en && (r_state == ST_IDLE) && (int'(wr_addr) < N*N);

   // Next state and next feed index; the counter is zero outside FEED
   always_comb begin
      w_state_next = r_state;
      w_t_next     = '0;
      case (r_state)
         ST_IDLE:  if (start) w_state_next = ST_CLEAR;
         ST_CLEAR: w_state_next = ST_FEED;
         ST_FEED: begin
            if (r_t == c_t_last)
               w_state_next = ST_DRAIN;
            else
               w_t_next = r_t + 1'b1;
         end
         ST_DRAIN: w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Skew muxes look at the next index so the edge registers present element t during cycle t
   skew_mux #(
      .N         (N),
      .DATA_W    (DATA_W),
      .T_W       (c_t_w),
      .TRANSPOSE (1'b0)
   ) u_skew_a (
      .i_t    (w_t_next),
      .i_buf  (r_a_buf),
      .o_edge (w_a_skew)
   );

   skew_mux #(
      .N         (N),
      .DATA_W    (DATA_W),
      .T_W       (c_t_w),
      .TRANSPOSE (1'b1)
   ) u_skew_b (
      .i_t    (w_t_next),
      .i_buf  (r_b_buf),
      .o_edge (w_b_skew)
   );

   // State and feed counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_t     <= '0;
      end else begin
         r_state <= w_state_next;
         r_t     <= w_t_next;
      end
   end

   // Registered outputs decoded from the upcoming state; edges are zero except in FEED
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_array_rst <= 1'b0;
         r_a_edge    <= '0;
         r_b_edge    <= '0;
      end else begin
         r_busy      <= (w_state_next != ST_IDLE);
         r_done      <= (w_state_next == ST_DONE);
         r_array_rst <= (w_state_next == ST_CLEAR);
         r_a_edge    <= (w_state_next == ST_FEED) ? w_a_skew : '0;
         r_b_edge    <= (w_state_next == ST_FEED) ? w_b_skew : '0;
      end
   end

   // Operand buffers, cleared by reset and written one element at a time
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a_buf <= '0;
         r_b_buf <= '0;
      end else if (w_wr_ok) begin
         if (wr_sel)
            r_b_buf[int'(wr_addr)*DATA_W +: DATA_W] <= wr_data;
         else
            r_a_buf[int'(wr_addr)*DATA_W +: DATA_W] <= wr_data;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign array_rst = r_array_rst;
   assign a_edge    = r_a_edge;
   assign b_edge    = r_b_edge;

`ifdef SYSTOLIC_CTRL_JOB_CNT_EN
   logic [31:0] r_job_count;

   // Count completed jobs; the value already includes the job whose done is showing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_job_count <= '0;
      else if (w_state_next == ST_DONE)
         r_job_count <= r_job_count + 32'd1;
   end

   assign job_count = r_job_count;
`endif

endmodule
`default_nettype wire

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for an N×N grid of the team's multiply-accumulate processing elements (PEs). Each PE passes `in_a` east and `in_b` south and accumulates `in_a*in_b` into a 17-bit `out_c`. This block holds operand matrices A and B in internal register buffers loaded through a write port. On `start` it clears the grid, then drives the west and north edges with diagonally skewed, zero-padded rows of A and columns of B. It reports completion when every PE accumulator holds its final C element.

Parameters:
- N, 4, array dimension (rows = cols = N), N >= 2
- DATA_W, 8, operand width; matches the PE operand ports
- ADDR_W, $clog2(N*N), element address width for the write port

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  operand write strobe
- wr_sel  in  1  0 selects A buffer, 1 selects B buffer
- wr_addr  in  ADDR_W  element index, row*N+col
- wr_data  in  DATA_W  operand value
- start  in  1  single-cycle job request
- busy  out  1  high from the CLEAR state through the DONE state
- done  out  1  single-cycle pulse when results are valid in the array
- array_rst  out  1  active-high clear to the PE reset inputs
- a_edge  out  N*DATA_W  west-edge feed; row i in bits [i*DATA_W +: DATA_W]
- b_edge  out  N*DATA_W  north-edge feed; col j in bits [j*DATA_W +: DATA_W]

Behaviour:
- Reset (`reset`=0, any time, including mid-job):
  - state=IDLE
  - busy=0, done=0, array_rst=0
  - a_edge=0, b_edge=0
  - feed counter=0
  - buffers cleared to 0
- State machine: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE: `start`=1 moves to CLEAR next cycle. All outputs are 0.
- CLEAR: lasts 1 cycle. array_rst=1, busy=1, edges=0.
- FEED: lasts exactly 3N-2 cycles; the counter t runs 0..3N-3. All outputs are registered and valid during cycle t:
  - a_edge row i = A[i][t-i] when 0 <= t-i < N, otherwise 0.
  - b_edge col j = B[t-j][j] when 0 <= t-j < N, otherwise 0.
  - Zero padding is mandatory; the PEs accumulate every cycle.
- DRAIN: lasts 1 cycle, edges=0. This lets the last product, presented at t=3N-3 to PE(N-1,N-1), register into `out_c`.
- DONE: done=1 for 1 cycle, busy=1, edges=0. Returns to IDLE.
- Latency: `start` sampled -> done high is 3N+1 cycles (1 CLEAR + 3N-2 FEED + 1 DRAIN + 1 DONE).
- Writes:
  - Accepted only in IDLE.
  - Ignored while busy=1, so buffer contents stay stable for the whole job.
  - A write with wr_addr >= N*N is ignored.
- Start and write in the same IDLE cycle: both take effect. The write lands before FEED begins.
- `start` while busy=1 is ignored; no queuing.
- Edge results after a job: PEs keep their accumulated values until the next CLEAR. The controller holds edges at 0 in IDLE, so the results are not disturbed.

Optional Feature:
- Macro: SYSTOLIC_CTRL_JOB_CNT_EN.
- When defined:
  - Adds output port `job_count` (32 bits).
  - Increments by 1 in each DONE cycle and wraps at 2^32-1 -> 0.
  - Cleared by reset.
- When undefined: the port and counter do not exist and all other behaviour is identical.

Decomposition:
- Shared package `systolic_pkg`:
  - state enum (IDLE, CLEAR, FEED, DRAIN, DONE)
  - default N and DATA_W constants
  - ACC_W=17 constant for the PE accumulator width
- Sub-module `skew_mux`: given the feed counter t and one buffer, produces one N-lane skewed, zero-padded edge vector. It is instantiated twice, once for A rows and once for B columns (transposed indexing via a parameter).

Test Plan:
1. N=2, load A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse start.
   - FEED t0: a=(1,0), b=(5,0). t1: a=(2,3), b=(7,6). t2: a=(0,4), b=(0,8). t3: zeros.
   - done arrives 7 cycles after start is sampled.
   - With a PE grid attached: C=[[19,22],[43,50]].
2. Reset mid-FEED at t=1.
   - All outputs go to 0 immediately (async), state=IDLE, buffers=0.
   - A following start feeds all-zero edges.
3. Pulse start during FEED, and write wr_addr=0 with wr_data=9 while busy.
   - No restart; the job completes unchanged.
   - A[0][0] stays 1, confirmed on the next job's t0 a_edge row0=1.
4. Same-cycle start and write of A[0][0]=10 in IDLE.
   - FEED t0 a_edge row0=10.
5. Two back-to-back jobs, with start pulsed again in the DONE cycle.
   - That start is ignored; array_rst pulses once per accepted start.
   - With SYSTOLIC_CTRL_JOB_CNT_EN, job_count=1 after the first job and 2 after the second.
6. N=4, A=identity, B[r][c]=4r+c+1.
   - Edges stay zero outside the skew window for all t.
   - C equals B.
